// File: rtl/iddmm_host.sv
// Initiator-side host for one IDDMM core: operand RAMs, task handshake, result capture and drain.
// Optional build macro IDDMM_HOST_WDOG_EN adds a REQ/COLLECT watchdog of TIMEOUT cycles.
module iddmm_host #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int ADDR_W  = $clog2(N),
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [1:0]        ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [K-1:0]      ld_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              task_req,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res,
  input  logic [ADDR_W:0]   rd_data_addr_i,
  input  logic [ADDR_W:0]   rd_data_addr_j,
  output logic [K-1:0]      x_word,
  output logic [K-1:0]      y_word,
  output logic [K-1:0]      m_word,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic              res_last
);

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, DRAIN} state_t;

  localparam logic [ADDR_W:0]   N_W    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(N-1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   wcnt, wcnt_nx;
  logic [ADDR_W-1:0] rcnt, rcnt_nx;
  logic              err_nx, done_nx;
  logic              armed, armed_nx;
  logic              active, cap, tmo;

  logic [K-1:0] x_mem [N];
  logic [K-1:0] y_mem [N];
  logic [K-1:0] m_mem [N];
  logic [K-1:0] r_mem [N];

  assign active    = (state == REQ) || (state == COLLECT);
  assign cap       = active && task_grant && (wcnt < N_W);
  assign task_req  = active;
  assign busy      = (state != IDLE);
  assign ld_ready  = (state == IDLE);
  assign res_valid = (state == DRAIN);
  assign res_data  = r_mem[rcnt];
  assign res_last  = res_valid && (rcnt == LAST_W);

`ifdef IDDMM_HOST_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT+1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_cnt <= '0;
    else if (!active || task_end) wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + 1'b1;
  end

  assign tmo = active && !task_end && (wd_cnt == WD_W'(TIMEOUT-1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
      rcnt  <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
      armed <= 1'b1;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      rcnt  <= rcnt_nx;
      err   <= err_nx;
      done  <= done_nx;
      armed <= armed_nx;
    end
  end

  // armed holds off a relaunch for one idle cycle after a timeout abort, so
  // task_req is low for two cycles and the controller's edge detector re-arms.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    rcnt_nx  = rcnt;
    err_nx   = err;
    done_nx  = 1'b0;
    armed_nx = armed;
    case (state)
      IDLE: begin
        armed_nx = 1'b1;
        if (start && armed) begin
          state_nx = REQ;
          wcnt_nx  = '0;
          rcnt_nx  = '0;
          err_nx   = 1'b0;
        end
        if (task_grant || task_end) err_nx = 1'b1;
      end
      REQ, COLLECT: begin
        if (cap) wcnt_nx = wcnt + 1'b1;
        if (task_grant && !cap) err_nx = 1'b1;
        if (state == REQ && task_grant) state_nx = COLLECT;
        if (task_end) begin
          state_nx = DRAIN;
          if (wcnt_nx != N_W) err_nx = 1'b1;
        end else if (tmo) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
          armed_nx = 1'b0;
        end
      end
      DRAIN: begin
        if (task_grant || task_end) err_nx = 1'b1;
        if (res_ready) begin
          rcnt_nx = rcnt + 1'b1;
          if (rcnt == LAST_W) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // RAMs carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && ld_valid) begin
      case (ld_sel)
        2'd0:    x_mem[ld_addr] <= ld_data;
        2'd1:    y_mem[ld_addr] <= ld_data;
        2'd2:    m_mem[ld_addr] <= ld_data;
        default: ;
      endcase
    end
    if (cap) r_mem[wcnt[ADDR_W-1:0]] <= task_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_word <= '0;
      y_word <= '0;
      m_word <= '0;
    end else begin
      x_word <= (rd_data_addr_i < N_W) ? x_mem[rd_data_addr_i[ADDR_W-1:0]] : '0;
      y_word <= (rd_data_addr_j < N_W) ? y_mem[rd_data_addr_j[ADDR_W-1:0]] : '0;
      m_word <= (rd_data_addr_j < N_W) ? m_mem[rd_data_addr_j[ADDR_W-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_iddmm_host.sv
// Directed bench for iddmm_host: operand reads, round trip, backpressure, short task, stray events.
module tb_iddmm_host;
  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid, ld_ready;
  logic [1:0]    ld_sel;
  logic [AW-1:0] ld_addr;
  logic [K-1:0]  ld_data;
  logic          start, busy, done, err, task_req;
  logic          task_grant, task_end;
  logic [K-1:0]  task_res;
  logic [AW:0]   rd_data_addr_i, rd_data_addr_j;
  logic [K-1:0]  x_word, y_word, m_word;
  logic          res_valid, res_ready, res_last;
  logic [K-1:0]  res_data;

  int n_vec = 0;
  int n_bad = 0;

  iddmm_host #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .task_req(task_req), .task_grant(task_grant), .task_end(task_end), .task_res(task_res),
    .rd_data_addr_i(rd_data_addr_i), .rd_data_addr_j(rd_data_addr_j),
    .x_word(x_word), .y_word(y_word), .m_word(m_word),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [K-1:0] got, input logic [K-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < 3; s++) begin
        ld_valid = 1'b1;
        ld_sel   = 2'(s);
        ld_addr  = AW'(i);
        ld_data  = K'(i + 1);
        @(negedge clk);
      end
    end
    ld_valid = 1'b0;
  endtask

  // Launch, play ngrant controller words (k*mul+add), then drain.
  // patt 0: res_ready always high; patt 1: ready 1,0,0 repeating.
  // stray: pulse start and an X write during DRAIN, both must be ignored.
  task automatic run_task(input int ngrant, input int mul, input int add, input int patt, input bit stray);
    int k, cyc;
    bit stalled, rdy;
    logic [K-1:0] prev, e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("req_rise", task_req, 1'b1);
    chk("busy_on", busy, 1'b1);
    chk("ld_ready_off", ld_ready, 1'b0);
    chk("err_clr", err, 1'b0);
    for (int i = 0; i < ngrant; i++) begin
      task_grant = 1'b1;
      task_res   = K'(i * mul + add);
      task_end   = (i == ngrant - 1);
      @(negedge clk);
    end
    task_grant = 1'b0;
    task_end   = 1'b0;
    chk("req_fall", task_req, 1'b0);
    k = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (k < N && cyc < 400) begin
      chk("res_valid", res_valid, 1'b1);
      if (stalled) chk("stall_hold", res_data, prev);
      if (k < ngrant) begin
        e = K'(k * mul + add);
        chk("res_data", res_data, e);
      end
      chk("res_last", res_last, k == N - 1);
      rdy       = (patt == 0) ? 1'b1 : (cyc % 3 == 0);
      res_ready = rdy;
      start     = stray && cyc == 4;
      ld_valid  = stray && cyc == 4;
      ld_sel    = 2'd0;
      ld_addr   = AW'(5);
      ld_data   = K'('hAA);
      prev      = res_data;
      stalled   = !rdy;
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    start     = 1'b0;
    ld_valid  = 1'b0;
    if (k < N) chk("drain_timeout", K'(k), K'(N));
    chk("done", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("valid_end", res_valid, 1'b0);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
    start = 1'b0; task_grant = 1'b0; task_end = 1'b0; task_res = '0;
    rd_data_addr_i = '0; rd_data_addr_j = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", task_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_last", res_last, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_x", x_word, '0);
    chk("rst_y", y_word, '0);
    chk("rst_m", m_word, '0);
    rst_n = 1'b1;
    @(negedge clk);

    load_ops();

    rd_data_addr_i = 6'd5;  rd_data_addr_j = 6'd32;
    @(negedge clk);
    chk("x_rd5", x_word, K'(6));
    chk("y_top", y_word, '0);
    chk("m_top", m_word, '0);
    rd_data_addr_i = 6'd32; rd_data_addr_j = 6'd0;
    @(negedge clk);
    chk("x_top", x_word, '0);
    chk("y_rd0", y_word, K'(1));
    chk("m_rd0", m_word, K'(1));
    rd_data_addr_i = 6'd31; rd_data_addr_j = 6'd31;
    @(negedge clk);
    chk("x_rd31", x_word, K'(32));
    chk("m_rd31", m_word, K'(32));

    run_task(32, 3, 0, 0, 1'b0);
    chk("err_round", err, 1'b0);

    run_task(32, 5, 7, 1, 1'b0);
    chk("err_bp", err, 1'b0);

    run_task(30, 3, 1, 1, 1'b1);
    chk("err_short", err, 1'b1);
    rd_data_addr_i = 6'd5;
    @(negedge clk);
    chk("x_no_busy_wr", x_word, K'(6));

    run_task(32, 2, 0, 0, 1'b0);
    chk("err_after_clr", err, 1'b0);

    task_grant = 1'b1;
    task_res   = K'('hDEAD);
    @(negedge clk);
    task_grant = 1'b0;
    chk("stray_err", err, 1'b1);
    chk("stray_busy", busy, 1'b0);
    chk("stray_req", task_req, 1'b0);
    @(negedge clk);
    chk("stray_x_kept", x_word, K'(6));

    run_task(32, 1, 9, 0, 1'b0);
    chk("err_final", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
